// File: rtl/cpu_check_monitor.sv
// Commit-event checker for a CPU under test.
// An expected-event table is loaded while IDLE. During RUN each observed
// commit event is compared in order against the next table entry. The run
// ends in PASS, FAIL or TIMEOUT and holds there until clear or rst.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | table load allowed, waiting for start
// RUN      | comparing commit events against table entries in order
// PASS     | every entry consumed with no mismatch
// FAIL     | mismatch seen (all entries consumed, or first one if STOP_ON_FAIL)
// TIMEOUT  | TIMEOUT_CYC consecutive RUN cycles without an event
module cpu_check_monitor #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 12,
  parameter int DEPTH        = 64,
  parameter int TIMEOUT_CYC  = 1024,
  parameter int STOP_ON_FAIL = 0,
  localparam int CNT_W       = $clog2(DEPTH + 1),
  localparam int IDX_W       = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              exp_wr_en_i,
  input  logic [1:0]        exp_kind_i,
  input  logic [ADDR_W-1:0] exp_addr_i,
  input  logic [DATA_W-1:0] exp_data_i,
  input  logic              start_i,
  input  logic              clear_i,
  input  logic              ev_valid_i,
  input  logic [1:0]        ev_kind_i,
  input  logic [ADDR_W-1:0] ev_addr_i,
  input  logic [DATA_W-1:0] ev_data_i,
  output logic [2:0]        state_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  entry_cnt_o,
  output logic [CNT_W-1:0]  checked_cnt_o,
  output logic [CNT_W-1:0]  mismatch_cnt_o,
  output logic [IDX_W-1:0]  fail_idx_o,
  output logic [DATA_W-1:0] fail_data_o,
  output logic              load_ovf_o
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [1:0]       KIND_OVF = 2'd2;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYC);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4
  } state_t;

  // Expected-event table; contents survive clear, only entry_cnt is emptied.
  logic [1:0]        kind_mem [DEPTH];
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  state_t            state_q;
  logic              done_q;
  logic [CNT_W-1:0]  entry_cnt_q;
  logic [CNT_W-1:0]  checked_cnt_q;
  logic [CNT_W-1:0]  mismatch_cnt_q;
  logic [CNT_W-1:0]  rd_q;
  logic [TMR_W-1:0]  tmr_q;
  logic [IDX_W-1:0]  fail_idx_q;
  logic [DATA_W-1:0] fail_data_q;
  logic              load_ovf_q;

  logic              tbl_full;
  logic              tbl_wr;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic [1:0]        rd_kind;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              ev_match;
  logic              last_entry;
  logic              no_prior_mm;

  assign tbl_full = (entry_cnt_q == DEPTH_C);
  assign tbl_wr   = !rst_i && !clear_i && (state_q == ST_IDLE) && exp_wr_en_i && !tbl_full;
  assign wr_idx   = entry_cnt_q[IDX_W-1:0];
  assign rd_idx   = rd_q[IDX_W-1:0];

  // Table is written only in IDLE and read only in RUN, so one port suffices.
  always_ff @(posedge clk_i) begin
    if (tbl_wr) begin
      kind_mem[wr_idx] <= exp_kind_i;
      addr_mem[wr_idx] <= exp_addr_i;
      data_mem[wr_idx] <= exp_data_i;
    end
  end

  assign rd_kind = kind_mem[rd_idx];
  assign rd_addr = addr_mem[rd_idx];
  assign rd_data = data_mem[rd_idx];

  // OVERFLOW entries carry only a flag in bit 0; their address is meaningless.
  always_comb begin
    ev_match = 1'b0;
    if (ev_kind_i == rd_kind) begin
      if (rd_kind == KIND_OVF) begin
        ev_match = (ev_data_i[0] == rd_data[0]);
      end else begin
        ev_match = (ev_addr_i == rd_addr) && (ev_data_i == rd_data);
      end
    end
  end

  assign last_entry  = (rd_q == (entry_cnt_q - CNT_W'(1)));
  assign no_prior_mm = (mismatch_cnt_q == '0);

  // Sequencing FSM; clear behaves like reset except the table keeps its data.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q        <= ST_IDLE;
      done_q         <= 1'b0;
      entry_cnt_q    <= '0;
      checked_cnt_q  <= '0;
      mismatch_cnt_q <= '0;
      rd_q           <= '0;
      tmr_q          <= '0;
      fail_idx_q     <= '0;
      fail_data_q    <= '0;
      load_ovf_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (exp_wr_en_i) begin
            if (tbl_full) begin
              load_ovf_q <= 1'b1;
            end else begin
              entry_cnt_q <= entry_cnt_q + CNT_W'(1);
            end
          end
          // Start looks at the count before any same-cycle write.
          if (start_i && (entry_cnt_q != '0)) begin
            state_q        <= ST_RUN;
            rd_q           <= '0;
            checked_cnt_q  <= '0;
            mismatch_cnt_q <= '0;
            tmr_q          <= TMR_LOAD;
          end
        end

        ST_RUN: begin
          if (ev_valid_i) begin
            checked_cnt_q <= checked_cnt_q + CNT_W'(1);
            rd_q          <= rd_q + CNT_W'(1);
            tmr_q         <= TMR_LOAD;
            if (!ev_match) begin
              if (mismatch_cnt_q != DEPTH_C) begin
                mismatch_cnt_q <= mismatch_cnt_q + CNT_W'(1);
              end
              if (no_prior_mm) begin
                fail_idx_q  <= rd_idx;
                fail_data_q <= ev_data_i;
              end
            end
            if (!ev_match && (STOP_ON_FAIL != 0)) begin
              state_q <= ST_FAIL;
              done_q  <= 1'b1;
            end else if (last_entry) begin
              state_q <= (ev_match && no_prior_mm) ? ST_PASS : ST_FAIL;
              done_q  <= 1'b1;
            end
          end else if (tmr_q == TMR_LAST) begin
            state_q <= ST_TIMEOUT;
            done_q  <= 1'b1;
          end else begin
            tmr_q <= tmr_q - TMR_W'(1);
          end
        end

        ST_PASS, ST_FAIL, ST_TIMEOUT: begin
          state_q <= state_q;
        end

        default: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign state_o        = state_q;
  assign done_o         = done_q;
  assign entry_cnt_o    = entry_cnt_q;
  assign checked_cnt_o  = checked_cnt_q;
  assign mismatch_cnt_o = mismatch_cnt_q;
  assign fail_idx_o     = fail_idx_q;
  assign fail_data_o    = fail_data_q;
  assign load_ovf_o     = load_ovf_q;

endmodule

// File: doc/cpu_check_monitor.md
CPU_CHECK_MONITOR -- requirements
Module: cpu_check_monitor

Interface
REQ-001 Parameter DATA_W, default 32, event/expected data width.
REQ-002 Parameter ADDR_W, default 12, event address width (register index zero-extended).
REQ-003 Parameter DEPTH, default 64, expected-table entries (power of 2, >=2).
REQ-004 Parameter TIMEOUT_CYC, default 1024, max idle cycles between events in RUN.
REQ-005 Parameter STOP_ON_FAIL, default 0, 1 = end run at first mismatch.
REQ-006 clk  in  1  single clock; all state changes on rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 exp_wr_en  in  1  write one expected entry (accepted only in IDLE).
REQ-009 exp_kind  in  2  expected kind: 0=REG write, 1=MEM write, 2=OVERFLOW, 3=reserved.
REQ-010 exp_addr  in  ADDR_W  expected register index / DM address.
REQ-011 exp_data  in  DATA_W  expected value (OVERFLOW: bit0 only).
REQ-012 start  in  1  pulse; begin checking.
REQ-013 clear  in  1  pulse; return to IDLE, empty table.
REQ-014 ev_valid, ev_kind(2), ev_addr(ADDR_W), ev_data(DATA_W)  in  observed commit event.
REQ-015 state  out  3  0=IDLE,1=RUN,2=PASS,3=FAIL,4=TIMEOUT.
REQ-016 done  out  1  high in PASS/FAIL/TIMEOUT.
REQ-017 entry_cnt, checked_cnt, mismatch_cnt  out  clog2(DEPTH+1) each.
REQ-018 fail_idx out clog2(DEPTH); fail_data out DATA_W; load_ovf out 1.

Function
REQ-019 IDLE: exp_wr_en stores entry at index entry_cnt, entry_cnt+1 next cycle.
REQ-020 Table full (entry_cnt==DEPTH): write discarded, load_ovf set sticky until clear/rst.
REQ-021 exp_wr_en outside IDLE is ignored, no flag.
REQ-022 IDLE + start + entry_cnt>0 -> RUN; rd pointer, checked_cnt, mismatch_cnt, idle timer zeroed; start with entry_cnt==0 ignored.
REQ-023 exp_wr_en and start same cycle in IDLE: write taken, start evaluated against pre-write entry_cnt.
REQ-024 RUN + ev_valid: compare kind, addr, data against entry[rd]; OVERFLOW compares kind and data bit0 only, addr ignored.
REQ-025 Match or mismatch: checked_cnt+1, rd+1, outputs visible the cycle after the event (1-cycle latency).
REQ-026 Mismatch: mismatch_cnt+1 (saturates at DEPTH); on first mismatch fail_idx=rd, fail_data=ev_data, later mismatches do not overwrite.
REQ-027 Event consuming entry entry_cnt-1 -> PASS if total mismatches 0 else FAIL.
REQ-028 STOP_ON_FAIL=1: first mismatch -> FAIL immediately, regardless of remaining entries.
REQ-029 Idle timer counts RUN cycles without ev_valid, resets on ev_valid; reaching TIMEOUT_CYC -> TIMEOUT.
REQ-030 ev_valid in the cycle timer would expire: event processed, timer cleared, no TIMEOUT.
REQ-031 ev_valid outside RUN ignored; counters unchanged.
REQ-032 PASS/FAIL/TIMEOUT hold all outputs until clear or rst; start ignored.
REQ-033 clear (any state, incl. mid-RUN): -> IDLE next cycle, all counters, fail_idx, fail_data, load_ovf zeroed; table contents need not be erased.
REQ-034 clear and start/ev_valid/exp_wr_en same cycle: clear wins, others dropped.
REQ-035 Single-port table: one write (IDLE) or one read (RUN) per cycle; no combinational path inputs->outputs.

Reset
REQ-036 rst high at a clock edge: state=IDLE, done=0, all counters=0, fail_idx=0, fail_data=0, load_ovf=0.
REQ-037 rst dominates clear, start, exp_wr_en, ev_valid; reset mid-RUN abandons run without PASS/FAIL.

Verification
REQ-038 Load {REG r0=0x80000000, OVF=1, MEM 4=0x7FFFFFFF}, start, send same 3 events with gaps of 0-5 cycles -> PASS, checked_cnt=3, mismatch_cnt=0.
REQ-039 Same table, 2nd event OVF=0, STOP_ON_FAIL=0 -> FAIL after 3rd event, mismatch_cnt=1, fail_idx=1, fail_data=0; with STOP_ON_FAIL=1 -> FAIL cycle after 2nd event, checked_cnt=2.
REQ-040 Load DEPTH+2 entries -> entry_cnt=DEPTH, load_ovf=1; run DEPTH matching events -> PASS.
REQ-041 TIMEOUT_CYC=8, start, no events -> TIMEOUT 8 cycles after RUN entry; event on cycle 8 instead -> stays RUN.
REQ-042 clear mid-RUN and simultaneous clear+ev_valid -> IDLE, counters 0; rst asserted in FAIL -> IDLE, all outputs 0.
